// File: rtl/sdpram_arbiter_if.sv
// Client and RAM-side signal bundle for sdpram_arbiter.
// The arbiter takes the slave modport; clients and the RAM model sit on master.
interface sdpram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              w0_req;
    logic              w1_req;
    logic [ADDR_W-1:0] w0_addr;
    logic [ADDR_W-1:0] w1_addr;
    logic [DATA_W-1:0] w0_data;
    logic [DATA_W-1:0] w1_data;
    logic              w0_gnt;
    logic              w1_gnt;

    logic              r0_req;
    logic              r1_req;
    logic [ADDR_W-1:0] r0_addr;
    logic [ADDR_W-1:0] r1_addr;
    logic              r0_gnt;
    logic              r1_gnt;
    logic              r0_rvalid;
    logic              r1_rvalid;
    logic [DATA_W-1:0] rdata;

    logic              wena;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              renb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;

    modport slave (
        input  w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data,
        input  r0_req, r1_req, r0_addr, r1_addr, doutb,
        output w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rdata,
        output wena, addra, dina, renb, addrb
    );

    modport master (
        output w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data,
        output r0_req, r1_req, r0_addr, r1_addr, doutb,
        input  w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rdata,
        input  wena, addra, dina, renb, addrb
    );
endinterface

// File: rtl/sdpram_arbiter.sv
// Round-robin arbiter for two writers on RAM port A and two readers on port B,
// with registered RAM commands and a 2-stage tag pipeline routing read data back.
module sdpram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    sdpram_arbiter_if.slave     bus
);
    typedef enum logic {FAV_0 = 1'b0, FAV_1 = 1'b1} rr_e;

    rr_e               wp_q, wp_d;
    rr_e               rp_q, rp_d;

    logic              w0_gnt, w1_gnt, w_any;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r0_elig, r1_elig;
    logic              r0_gnt, r1_gnt, r_any;
    logic [ADDR_W-1:0] r_addr;

    logic              wena_q;
    logic [ADDR_W-1:0] addra_q;
    logic [DATA_W-1:0] dina_q;
    logic              renb_q;
    logic [ADDR_W-1:0] addrb_q;
    logic              s1_vld_q, s1_id_q;
    logic              s2_vld_q, s2_id_q;

    always_comb begin
        w0_gnt  = 1'b0;
        w1_gnt  = 1'b0;
        r0_gnt  = 1'b0;
        r1_gnt  = 1'b0;
        if (rst) begin
            w0_gnt = bus.w0_req & (~bus.w1_req | (wp_q == FAV_0));
            w1_gnt = bus.w1_req & (~bus.w0_req | (wp_q == FAV_1));
        end
        w_any  = w0_gnt | w1_gnt;
        w_addr = w1_gnt ? bus.w1_addr : bus.w0_addr;
        w_data = w1_gnt ? bus.w1_data : bus.w0_data;

        // A reader hitting this cycle's write address is skipped so it retries and sees the new data.
        r0_elig = rst & bus.r0_req & ~(w_any & (bus.r0_addr == w_addr));
        r1_elig = rst & bus.r1_req & ~(w_any & (bus.r1_addr == w_addr));
        r0_gnt  = r0_elig & (~r1_elig | (rp_q == FAV_0));
        r1_gnt  = r1_elig & (~r0_elig | (rp_q == FAV_1));
        r_any   = r0_gnt | r1_gnt;
        r_addr  = r1_gnt ? bus.r1_addr : bus.r0_addr;

        wp_d = wp_q;
        if (w0_gnt)      wp_d = FAV_1;
        else if (w1_gnt) wp_d = FAV_0;

        rp_d = rp_q;
        if (r0_gnt)      rp_d = FAV_1;
        else if (r1_gnt) rp_d = FAV_0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q     <= FAV_0;
            rp_q     <= FAV_0;
            wena_q   <= 1'b0;
            addra_q  <= '0;
            dina_q   <= '0;
            renb_q   <= 1'b0;
            addrb_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_id_q  <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            wena_q   <= w_any;
            renb_q   <= r_any;
            if (w_any) begin
                addra_q <= w_addr;
                dina_q  <= w_data;
            end
            if (r_any) begin
                addrb_q <= r_addr;
            end
            s1_vld_q <= r_any;
            s1_id_q  <= r1_gnt;
            s2_vld_q <= s1_vld_q;
            s2_id_q  <= s1_id_q;
        end
    end

    assign bus.w0_gnt    = w0_gnt;
    assign bus.w1_gnt    = w1_gnt;
    assign bus.r0_gnt    = r0_gnt;
    assign bus.r1_gnt    = r1_gnt;
    assign bus.wena      = wena_q;
    assign bus.addra     = addra_q;
    assign bus.dina      = dina_q;
    assign bus.renb      = renb_q;
    assign bus.addrb     = addrb_q;
    assign bus.r0_rvalid = s2_vld_q & ~s2_id_q;
    assign bus.r1_rvalid = s2_vld_q &  s2_id_q;
    assign bus.rdata     = bus.doutb;
endmodule

// File: doc/sdpram_arbiter.md
# sdpram_arbiter

Two-writer / two-reader arbiter and sequencer for the simple dual-port RAM: it shares write port A between two write requesters and read port B between two read requesters, using independent round-robin arbitration per port. It drives registered RAM commands, returns read data with a routed valid pulse, and holds off any read that collides with a same-cycle write to the same address. It sits between the client blocks and simple_dual_port_ram, connecting to the RAM's port signals.

## Interface
- ADDR_W, 10, RAM address width
- DATA_W, 32, RAM data width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- w0_req, w1_req  in  1 each  write request, held until granted
- w0_addr, w1_addr  in  ADDR_W each  write address
- w0_data, w1_data  in  DATA_W each  write data
- w0_gnt, w1_gnt  out  1 each  combinational grant; the write is accepted on a clock edge where req & gnt
- r0_req, r1_req  in  1 each  read request, held until granted
- r0_addr, r1_addr  in  ADDR_W each  read address
- r0_gnt, r1_gnt  out  1 each  combinational read grant
- r0_rvalid, r1_rvalid  out  1 each  one-cycle read-data-valid pulse to the owning reader
- rdata  out  DATA_W  read data, shared by both readers; qualified by rN_rvalid
- wena, addra, dina  out  1/ADDR_W/DATA_W  registered RAM port A command
- renb, addrb  out  1/ADDR_W  registered RAM port B command
- doutb  in  DATA_W  RAM port B read data, valid one cycle after renb is sampled

## Operation
- Write arbitration:
  - At most one write grant per cycle.
  - A round-robin pointer wp selects the favoured requester; wp resets to 0.
  - If both writers request, grant the favoured one. If only one requests, grant it.
  - On a grant, wp moves to the other requester. With no grant, wp holds.
- Read arbitration: the same scheme with its own pointer rp, reset 0, plus the collision rule below.
- Collision rule:
  - A reader is eligible only if its address differs from the address of the write granted in the same cycle.
  - An ineligible reader is skipped. The other reader may still win if eligible.
  - rp updates only on an actual grant.
  - A skipped read is retried next cycle and returns the newly written data.
- Command registers, loaded on every edge:
  - wena <= any write grant; addra/dina <= winner's address/data. They hold their last values when wena is 0.
  - renb <= any read grant; addrb <= winner's address.
- Read return:
  - A 2-stage tag pipeline carries {valid, reader id}. Stage 1 is loaded alongside renb; stage 2 is loaded from stage 1.
  - rN_rvalid = stage2.valid & (stage2.id == N).
  - rdata = doutb, passed through combinationally.
- Multiple reads are pipelined back-to-back: one grant per cycle, responses returned in grant order.

## Timing
- Reset (rst low, asynchronous):
  - wena, renb, addra, dina, addrb, all rvalid and the tag pipeline clear to 0.
  - wp and rp clear to 0.
  - Grants are forced to 0 while rst is low.
  - In-flight read responses are dropped; no rvalid appears after reset is released.
- Write latency: grant in cycle n -> wena = 1 in cycle n+1 -> RAM write at the end of cycle n+1.
- Read latency:
  - Grant in cycle n -> renb = 1 in cycle n+1 -> doutb valid and rN_rvalid = 1 in cycle n+2.
  - Fixed latency of 2 cycles from grant.
- Throughput: one write and one read per cycle sustained, with no bubbles except collision holds.
- A write and a read to different addresses in the same cycle are both granted.
- A read to the address being written in the current RAM cycle (wena = 1) is legal; that write completed on the previous edge relative to the read sample.

## Test plan
- Reset then single write: w0 writes addr 5 = 350 -> w0_gnt in the same cycle; wena = 1, addra = 5, dina = 350 one cycle later. r0 then reads addr 5 -> r0_rvalid 2 cycles after r0_gnt with rdata = 350.
- Round-robin write: w0 and w1 both request continuously (addr 5 = 350, addr 7 = 670) -> grants alternate w0, w1, w0, ...; a solo w1 request after reset is granted immediately.
- Read contention: r0 reads addr 5 and r1 reads addr 7 in the same cycle -> r0 is granted first, r1 next cycle; rvalid pulses land on r0 then r1 in consecutive cycles with 350 and 670.
- Collision: w0 writes addr 5 = 961 while r0 reads addr 5 in the same cycle -> r0_gnt = 0 that cycle, granted next cycle; rdata = 961. In the same setup an r1 read of addr 7 is granted in the collision cycle.
- Reset mid-operation: assert rst one cycle after a read grant -> renb and rvalid are 0 immediately; no rvalid after release; wp and rp return to 0.
- Back-to-back reads: r0 reads addrs 0..7 on 8 consecutive cycles -> 8 consecutive r0_rvalid pulses in address order, with no gaps.
